// File: rtl/ram_pkg.sv
// Shared types and helpers for cleared_ram: FSM states, read-during-write modes, parity.
// Pure declarations, no timing or flow control of its own.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [31:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: zeroes one word per cycle after reset, then raises ready; SIZE cycles total.
// No backpressure; ready stays low for the whole sweep and high until the next reset.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int SIZE_LOG = 8
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  output logic                clr_en,
  output logic [SIZE_LOG-1:0] clr_addr
);

  ram_state_e          state_q, state_d;
  logic [SIZE_LOG-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_en   = 1'b0;
    clr_addr = cnt_q;
    if (state_q == CLEAR) begin
      clr_en = 1'b1;
      // Counter parks on the last address instead of wrapping.
      if (cnt_q == {SIZE_LOG{1'b1}}) begin
        state_d = READY;
      end else begin
        cnt_d = cnt_q + SIZE_LOG'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready = (state_q == READY);

endmodule

// File: rtl/cleared_ram.sv
// Single-port bit-masked RAM self-cleared after reset; 1-cycle read latency, requests dropped while ready=0.
// Optional stored even parity with fault injection when CLEARED_RAM_PARITY_EN is defined.
module cleared_ram
  import ram_pkg::*;
#(
  parameter int WORD     = 1,
  parameter int SIZE_LOG = 8,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read,
  input  logic                write,
  input  logic [SIZE_LOG-1:0] address,
  input  logic [WORD-1:0]     data_in,
  input  logic [WORD-1:0]     wmask,
  input  logic                inject,
  output logic [WORD-1:0]     data_out,
  output logic                rvalid,
  output logic                ready,
  output logic                parity_err
);

  localparam int SIZE = 1 << SIZE_LOG;

  logic [WORD-1:0]     mem_q [SIZE];
  logic                clr_en;
  logic [SIZE_LOG-1:0] clr_addr;
  logic                rd_acc, wr_acc, mem_we;
  logic [SIZE_LOG-1:0] mem_waddr;
  logic [WORD-1:0]     old_word, merged, rd_word, mem_wdat;
  logic [WORD-1:0]     data_out_q, data_out_d;
  logic                rvalid_q, rvalid_d;
  logic                parity_err_q, parity_err_d;

  ram_clear_seq #(.SIZE_LOG(SIZE_LOG)) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  always_comb begin
    rd_acc     = read & ready & ~reset;
    wr_acc     = write & ready & ~reset;
    old_word   = mem_q[address];
    merged     = (old_word & ~wmask) | (data_in & wmask);
    mem_we     = clr_en | wr_acc;
    mem_waddr  = clr_en ? clr_addr : address;
    mem_wdat   = clr_en ? '0 : merged;
    rd_word    = (RDW_MODE == RDW_NEW && wr_acc) ? merged : old_word;
    data_out_d = rd_acc ? rd_word : data_out_q;
    rvalid_d   = rd_acc;
  end

`ifdef CLEARED_RAM_PARITY_EN
  logic par_q [SIZE];
  logic par_wdat, rd_par;

  always_comb begin
    par_wdat     = clr_en ? 1'b0 : (even_parity(32'(merged)) ^ inject);
    // A same-cycle write in new-data mode must be checked against its own parity.
    rd_par       = (RDW_MODE == RDW_NEW && wr_acc) ? par_wdat : par_q[address];
    parity_err_d = rd_acc & (rd_par != even_parity(32'(rd_word)));
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_q[mem_waddr] <= par_wdat;
    end
  end
`else
  logic unused_inject;
  assign unused_inject = inject;

  always_comb begin
    parity_err_d = 1'b0;
  end
`endif

  // Storage has no reset; the clear sweep defines it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q   <= '0;
      rvalid_q     <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      rvalid_q     <= rvalid_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign rvalid     = rvalid_q;
  assign parity_err = parity_err_q;

endmodule
